// File: rtl/demux_key_stream.sv
// Key-routed demux: each input word goes to the lowest lane whose lut key matches, into a 2-deep per-lane FIFO.
// Latency 1 from input transfer to out_valid; a full lane stalls only words aimed at it, and unmatched words are always accepted and dropped.
module demux_key_stream #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_KEY*KEY_LEN-1:0]    lut,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [KEY_LEN-1:0]           in_key,
  input  logic [DATA_LEN-1:0]          in_data,
  output logic [NR_KEY-1:0]            out_valid,
  input  logic [NR_KEY-1:0]            out_ready,
  output logic [NR_KEY*DATA_LEN-1:0]   out_data,
  output logic [7:0]                   miss_cnt,
  output logic                         miss_flag
);

  logic [DATA_LEN-1:0] head_q [NR_KEY];
  logic [DATA_LEN-1:0] head_d [NR_KEY];
  logic [DATA_LEN-1:0] tail_q [NR_KEY];
  logic [DATA_LEN-1:0] tail_d [NR_KEY];
  logic [1:0]          occ_q  [NR_KEY];
  logic [1:0]          occ_d  [NR_KEY];
  logic [7:0]          miss_cnt_q, miss_cnt_d;
  logic                miss_flag_q, miss_flag_d;

  logic [NR_KEY-1:0]   sel_oh;
  logic [NR_KEY-1:0]   pop;
  logic [NR_KEY-1:0]   room;
  logic [NR_KEY-1:0]   push;
  logic                hit;
  logic                xfer;
  logic                miss;

  // Priority match: first (lowest) matching lane claims the word.
  always_comb begin
    sel_oh = '0;
    hit    = 1'b0;
    for (int n = 0; n < NR_KEY; n++) begin
      if (!hit && (in_key == lut[n*KEY_LEN +: KEY_LEN])) begin
        sel_oh[n] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  always_comb begin
    pop  = '0;
    room = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      pop[n]  = (occ_q[n] != 2'd0) && out_ready[n];
      room[n] = (occ_q[n] != 2'd2) || pop[n];
    end
  end

  assign in_ready = !rst && (!hit || |(sel_oh & room));
  assign xfer     = in_valid && in_ready;
  assign push     = xfer ? sel_oh : '0;
  assign miss     = xfer && !hit;

  // head is the registered output word; tail only holds the second entry.
  always_comb begin
    for (int n = 0; n < NR_KEY; n++) begin
      head_d[n] = head_q[n];
      tail_d[n] = tail_q[n];
      occ_d[n]  = occ_q[n];
      case ({push[n], pop[n]})
        2'b10: begin
          if (occ_q[n] == 2'd0) head_d[n] = in_data;
          else                  tail_d[n] = in_data;
          occ_d[n] = occ_q[n] + 2'd1;
        end
        2'b01: begin
          head_d[n] = tail_q[n];
          occ_d[n]  = occ_q[n] - 2'd1;
        end
        2'b11: begin
          if (occ_q[n] == 2'd1) begin
            head_d[n] = in_data;
          end else begin
            head_d[n] = tail_q[n];
            tail_d[n] = in_data;
          end
        end
        default: ;
      endcase
    end
    miss_cnt_d  = (miss && (miss_cnt_q != 8'hFF)) ? miss_cnt_q + 8'd1 : miss_cnt_q;
    miss_flag_d = miss_flag_q || miss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NR_KEY; n++) begin
        head_q[n] <= '0;
        tail_q[n] <= '0;
        occ_q[n]  <= 2'd0;
      end
      miss_cnt_q  <= 8'h00;
      miss_flag_q <= 1'b0;
    end else begin
      for (int n = 0; n < NR_KEY; n++) begin
        head_q[n] <= head_d[n];
        tail_q[n] <= tail_d[n];
        occ_q[n]  <= occ_d[n];
      end
      miss_cnt_q  <= miss_cnt_d;
      miss_flag_q <= miss_flag_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      out_valid[n]                        = (occ_q[n] != 2'd0);
      out_data[n*DATA_LEN +: DATA_LEN]    = head_q[n];
    end
  end

  assign miss_cnt  = miss_cnt_q;
  assign miss_flag = miss_flag_q;

endmodule

// File: tb/tb_demux_key_stream.sv
// Scoreboard bench for demux_key_stream: per-lane expected queues fed on accepted input, checked against lane heads.
module tb_demux_key_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lut;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_key;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [7:0]  miss_cnt;
  logic        miss_flag;

  int checks   = 0;
  int failures = 0;

  typedef logic [7:0] q_t[$];
  q_t mq[4];
  int m_cnt;
  logic m_flag;
  int lane;
  logic exp_rdy;

  demux_key_stream dut (
    .clk(clk), .rst(rst), .lut(lut),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .miss_cnt(miss_cnt), .miss_flag(miss_flag)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_lane(input logic [7:0] l, input logic [1:0] k);
    for (int n = 0; n < 4; n++) begin
      logic [7:0] sh;
      sh = l >> (2*n);
      if (sh[1:0] == k) return n;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable across the negedge, so this sees exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      m_cnt  = 0;
      m_flag = 1'b0;
      check_val("rst_in_ready", in_ready, 0);
    end else begin
      lane    = model_lane(lut, in_key);
      exp_rdy = (lane < 0) ? 1'b1 : ((mq[lane].size() < 2) || out_ready[lane]);
      check_val("in_ready", in_ready, exp_rdy);
      for (int n = 0; n < 4; n++) begin
        check_val("out_valid", out_valid[n], mq[n].size() > 0);
        if (mq[n].size() > 0) check_val("out_data", out_data[n*8 +: 8], mq[n][0]);
      end
      check_val("miss_cnt", miss_cnt, m_cnt);
      check_val("miss_flag", miss_flag, m_flag);
      for (int n = 0; n < 4; n++)
        if (mq[n].size() > 0 && out_ready[n]) void'(mq[n].pop_front());
      if (in_valid && exp_rdy) begin
        if (lane < 0) begin
          if (m_cnt < 255) m_cnt++;
          m_flag = 1'b1;
        end else begin
          mq[lane].push_back(in_data);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    lut       = {2'b00, 2'b01, 2'b10, 2'b11};
    in_valid  = 1'b0;
    in_key    = 2'b00;
    in_data   = 8'h00;
    out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;
    #1;
    check_val("reset_out_valid", out_valid, 4'b0000);
    check_val("reset_out_data", out_data, 32'h0);
    check_val("reset_miss_cnt", miss_cnt, 8'h00);
    check_val("reset_miss_flag", miss_flag, 1'b0);

    // single word to lane0, visible one cycle later
    in_valid = 1'b1; in_key = 2'b11; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    #1;
    check_val("lat1_valid", out_valid, 4'b0001);
    check_val("lat1_data", out_data[7:0], 8'hA5);
    out_ready = 4'b0001;
    step();
    out_ready = 4'b0000;

    // lane1 fills at two, third accepted on the pop cycle
    in_valid = 1'b1; in_key = 2'b10; in_data = 8'h01;
    step();
    in_data = 8'h02;
    step();
    in_data = 8'h03;
    #1;
    check_val("full_blocks", in_ready, 1'b0);
    step();
    out_ready = 4'b0010;
    #1;
    check_val("accept_on_pop", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    check_val("order_02", out_data[15:8], 8'h02);
    step();
    #1;
    check_val("order_03", out_data[15:8], 8'h03);
    step();
    out_ready = 4'b0000;
    #1;
    check_val("lane1_drained", out_valid[1], 1'b0);

    // duplicate keys: lowest matching lane wins
    lut = {2'b01, 2'b01, 2'b00, 2'b10};
    in_valid = 1'b1; in_key = 2'b01; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    #1;
    check_val("dup_lane2", out_valid, 4'b0100);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;

    // full lane1 blocks only its own word; lane0 still flows
    lut = {2'b00, 2'b01, 2'b10, 2'b11};
    in_valid = 1'b1; in_key = 2'b10; in_data = 8'h11;
    step();
    in_data = 8'h12;
    step();
    in_data = 8'h13;
    #1;
    check_val("hol_blocked", in_ready, 1'b0);
    step(); step(); step();
    in_key = 2'b11; in_data = 8'h21;
    #1;
    check_val("other_lane_ready", in_ready, 1'b1);
    step();
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    #1;
    check_val("two_lanes_full", out_valid, 4'b0011);
    out_ready = 4'b1111;
    step(); step();
    out_ready = 4'b0000;

    // 300 unmatched words: always ready, counter saturates
    lut = {2'b01, 2'b01, 2'b10, 2'b11};
    in_valid = 1'b1; in_key = 2'b00;
    for (int i = 0; i < 300; i++) begin
      in_data = i[7:0];
      step();
    end
    in_valid = 1'b0;
    #1;
    check_val("sat_cnt", miss_cnt, 8'hFF);
    check_val("sat_flag", miss_flag, 1'b1);
    check_val("sat_no_valid", out_valid, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      in_key = i[1:0];
      step();
    end

    // reset mid-operation discards queued words
    lut = {2'b00, 2'b01, 2'b10, 2'b11};
    in_valid = 1'b1; in_key = 2'b11; in_data = 8'hA0;
    step();
    in_key = 2'b01; in_data = 8'hB0;
    step();
    in_valid = 1'b0;
    #1;
    check_val("pre_rst_valid", out_valid, 4'b0101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 4'b0000);
    check_val("mid_rst_cnt", miss_cnt, 8'h00);
    check_val("mid_rst_flag", miss_flag, 1'b0);
    in_valid = 1'b1; in_key = 2'b11; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    #1;
    check_val("post_rst_valid", out_valid, 4'b0001);
    check_val("post_rst_data", out_data[7:0], 8'h5A);

    // random traffic with occasional lut changes, checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) lut = 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      in_key    = 2'($urandom);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    step(); step(); step();
    for (int n = 0; n < 4; n++) check_val("final_empty", out_valid[n], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_key_stream.md
DEMUX_KEY_STREAM -- requirements
Module: demux_key_stream

Interface
REQ-001 Parameter NR_KEY, default 4, number of output lanes.
REQ-002 Parameter KEY_LEN, default 2, key width in bits.
REQ-003 Parameter DATA_LEN, default 8, payload width in bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 lut  input  NR_KEY*KEY_LEN  key table; lane n key = lut[KEY_LEN*(n+1)-1 : KEY_LEN*n]; quasi-static.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block accepts upstream word this cycle.
REQ-009 in_key  input  KEY_LEN  routing key of upstream word.
REQ-010 in_data  input  DATA_LEN  upstream payload.
REQ-011 out_valid  output  NR_KEY  bit n: lane n head word valid.
REQ-012 out_ready  input  NR_KEY  bit n: lane n consumer takes head word.
REQ-013 out_data  output  NR_KEY*DATA_LEN  lane n head payload at bits [DATA_LEN*(n+1)-1 : DATA_LEN*n].
REQ-014 miss_cnt  output  8  saturating count of dropped (unmatched) words.
REQ-015 miss_flag  output  1  sticky: set on first dropped word.

Function
REQ-016 The block SHALL compute hit = OR over n of (in_key == key_n); selected lane = lowest n with a match (duplicate keys: lowest index wins).
REQ-017 Each lane SHALL hold a 2-entry FIFO; occupancy 0, 1 or 2; head word drives out_data slice.
REQ-018 out_valid[n] SHALL be 1 iff lane n occupancy > 0; out_valid and out_data SHALL be registered (no combinational path from in_* to out_*).
REQ-019 Lane pop SHALL occur on a cycle with out_valid[n] & out_ready[n]; head advances to next entry or lane becomes empty.
REQ-020 in_ready SHALL be 1 when hit is 0 (miss words always accepted and dropped).
REQ-021 On hit, in_ready SHALL be 1 iff selected lane occupancy < 2, or occupancy == 2 and that lane pops this cycle.
REQ-022 An input transfer SHALL occur on in_valid & in_ready; on hit the word is written to the selected lane tail, visible at out_valid one cycle later (latency 1).
REQ-023 Simultaneous push and pop on one lane SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 Lanes SHALL be independent: a full lane SHALL not stall words routed to other lanes; head-of-line blocking applies only to the input word itself.
REQ-025 On a miss transfer, miss_cnt SHALL increment by 1, saturating at 8'hFF (no wrap), and miss_flag SHALL set to 1.
REQ-026 When in_valid is 0, no lane write, counter change or flag change SHALL occur regardless of in_key.
REQ-027 lut changes SHALL affect routing from the same cycle combinationally; words already queued SHALL stay in their lane.
REQ-028 in_ready MAY depend combinationally on in_key, lut and out_ready; in_ready SHALL not depend on in_valid.

Reset
REQ-029 With rst high at a rising edge, all lane occupancies SHALL become 0, out_valid SHALL be 0, miss_cnt 8'h00, miss_flag 0.
REQ-030 out_data SHALL be 0 after reset until first write to that lane.
REQ-031 Reset mid-operation SHALL discard all queued words; no transfer is accepted during a cycle in which rst is high (in_ready forced 0).

Verification
REQ-032 Defaults, lut = {2'b00,2'b01,2'b10,2'b11} (lane0 key 11, lane3 key 00); push key 11 data 8'hA5, out_ready=0 -> next cycle out_valid=4'b0001, lane0 data 8'hA5.
REQ-033 Push key 10 data 8'h01, 8'h02, 8'h03 with out_ready[1]=0 -> first two accepted, in_ready=0 on third; raise out_ready[1] -> pops 01, 02, 03 in order, third accepted on the pop cycle.
REQ-034 lut = {2'b01,2'b01,2'b00,2'b10}, push key 01 -> word lands in lane 2 only (lowest matching index).
REQ-035 lut with no key 00; push 300 words key 00 -> in_ready=1 throughout, out_valid=0, miss_cnt=8'hFF, miss_flag=1.
REQ-036 Lane1 full and stalled; alternate pushes key 10 (blocked) then key 11 -> key 11 word waits behind blocked word; separately, key 11 pushes proceed to lane0 while lane1 stays full.
REQ-037 Fill lanes 0 and 2, assert rst one cycle -> out_valid=0, miss_cnt=0, miss_flag=0; next push key 11 data 8'h5A appears on lane0 after one cycle.
